// File: rtl/ir_packet_tx.sv
// IR car-control packet transmitter: every TICK_CYCLES it sends start, car-select and four direction bursts, each followed by a gap.
// car packing (MSB first): {half_period, start_burst, car_select_burst, gap_size, assert_burst, deassert_burst}.
module ir_packet_tx #(
  parameter int TICK_CYCLES = 10_000_000,
  parameter int HP_W        = 16,
  parameter int CNT_W       = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [HP_W+5*CNT_W-1:0]   car,
  input  logic [3:0]                command,
  output logic                      ir_led,
  output logic                      busy,
  output logic                      packet_done
);

  localparam int CAR_W = HP_W + 5*CNT_W;
  localparam int TW    = $clog2(TICK_CYCLES + 1);

  // Segment index doubles as the FSM state; even = burst, odd = gap.
  localparam logic [3:0] SEG_START  = 4'd0;
  localparam logic [3:0] SEG_SELECT = 4'd2;
  localparam logic [3:0] SEG_RIGHT  = 4'd4;
  localparam logic [3:0] SEG_LEFT   = 4'd6;
  localparam logic [3:0] SEG_BACK   = 4'd8;
  localparam logic [3:0] SEG_FWD    = 4'd10;
  localparam logic [3:0] SEG_END    = 4'd12;

  function automatic logic [CNT_W-1:0] seg_count(input logic [3:0] s,
                                                 input logic [CAR_W-1:0] c,
                                                 input logic [3:0] cmd);
    logic [CNT_W-1:0] st, sel, gap, asb, deb, r;
    {st, sel, gap, asb, deb} = c[5*CNT_W-1:0];
    r = '0;
    if (s[0] && s < SEG_END) r = gap;
    else begin
      case (s)
        SEG_START:  r = st;
        SEG_SELECT: r = sel;
        SEG_RIGHT:  r = cmd[0] ? asb : deb;
        SEG_LEFT:   r = cmd[1] ? asb : deb;
        SEG_BACK:   r = cmd[2] ? asb : deb;
        SEG_FWD:    r = cmd[3] ? asb : deb;
        default:    r = '0;
      endcase
    end
    return r;
  endfunction

  // First segment at or after 'from' with a nonzero count, so empty segments cost no cycles.
  function automatic logic [3:0] first_seg(input logic [3:0] from,
                                           input logic [CAR_W-1:0] c,
                                           input logic [3:0] cmd);
    logic [3:0] r;
    r = SEG_END;
    for (int i = 11; i >= 0; i--)
      if (4'(i) >= from && seg_count(4'(i), c, cmd) != '0) r = 4'(i);
    return r;
  endfunction

  logic [TW-1:0]    tick_cnt;
  logic [CAR_W-1:0] car_q;
  logic [3:0]       cmd_q;
  logic [3:0]       seg;
  logic [CNT_W-1:0] pcnt;
  logic [HP_W-1:0]  hcnt;
  logic             phase;

  logic             tick;
  logic [HP_W-1:0]  hp_f, hp_m1;
  logic             half_end;
  logic [3:0]       launch_seg, nxt_seg;

  always_comb begin
    tick       = (tick_cnt == TW'(TICK_CYCLES - 1));
    hp_f       = car_q[CAR_W-1 -: HP_W];
    hp_m1      = (hp_f == '0) ? '0 : hp_f - HP_W'(1);
    half_end   = (hcnt == hp_m1);
    launch_seg = first_seg(SEG_START, car, command);
    nxt_seg    = first_seg(seg + 4'd1, car_q, cmd_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt    <= '0;
      car_q       <= '0;
      cmd_q       <= '0;
      seg         <= SEG_START;
      pcnt        <= '0;
      hcnt        <= '0;
      phase       <= 1'b0;
      busy        <= 1'b0;
      ir_led      <= 1'b0;
      packet_done <= 1'b0;
    end else begin
      tick_cnt    <= tick ? '0 : tick_cnt + TW'(1);
      packet_done <= 1'b0;
      if (!busy) begin
        ir_led <= 1'b0;
        if (tick) begin
          car_q <= car;
          cmd_q <= command;
          seg   <= launch_seg;
          pcnt  <= seg_count(launch_seg, car, command);
          hcnt  <= '0;
          phase <= 1'b0;
          if (launch_seg == SEG_END) packet_done <= 1'b1;
          else begin
            busy   <= 1'b1;
            ir_led <= ~launch_seg[0];
          end
        end
      end else if (half_end) begin
        hcnt <= '0;
        if (!phase) begin
          phase  <= 1'b1;
          ir_led <= 1'b0;
        end else if (pcnt != CNT_W'(1)) begin
          phase  <= 1'b0;
          pcnt   <= pcnt - CNT_W'(1);
          ir_led <= ~seg[0];
        end else if (nxt_seg == SEG_END) begin
          busy        <= 1'b0;
          packet_done <= 1'b1;
          ir_led      <= 1'b0;
        end else begin
          seg    <= nxt_seg;
          pcnt   <= seg_count(nxt_seg, car_q, cmd_q);
          phase  <= 1'b0;
          ir_led <= ~nxt_seg[0];
        end
      end else begin
        hcnt <= hcnt + HP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ir_packet_tx.sv
// Directed bench for ir_packet_tx: packet length, pulse count and waveform against a reference built from the settings.
module tb_ir_packet_tx;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [55:0] car;
  logic [3:0]  command;
  logic        ir_led, busy, packet_done;
  logic        ir_led_b, busy_b, packet_done_b;

  always #5 clk = ~clk;

  ir_packet_tx #(.TICK_CYCLES(100)) dut (
    .clk(clk), .reset(reset), .car(car), .command(command),
    .ir_led(ir_led), .busy(busy), .packet_done(packet_done));

  ir_packet_tx #(.TICK_CYCLES(50)) dut_b (
    .clk(clk), .reset(reset), .car(car), .command(command),
    .ir_led(ir_led_b), .busy(busy_b), .packet_done(packet_done_b));

  int checks = 0, passed = 0, fails = 0;
  bit wave[256];
  bit exp_wave[256];
  int exp_len;
  logic [55:0] pend_car;
  logic [3:0]  pend_cmd;

  function automatic logic [55:0] mk_car(input int hp, input int st, input int sel,
                                         input int gap, input int asb, input int deb);
    return {hp[15:0], st[7:0], sel[7:0], gap[7:0], asb[7:0], deb[7:0]};
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference waveform straight from the segment list.
  task automatic build_expected(input int hp_raw, input int st, input int sel, input int gap,
                                input int asb, input int deb, input logic [3:0] cmd);
    int h;
    int cnt[12];
    h = (hp_raw == 0) ? 1 : hp_raw;
    cnt[0] = st;  cnt[2] = sel;
    cnt[4] = cmd[0] ? asb : deb;  cnt[6]  = cmd[1] ? asb : deb;
    cnt[8] = cmd[2] ? asb : deb;  cnt[10] = cmd[3] ? asb : deb;
    for (int s = 1; s < 12; s += 2) cnt[s] = gap;
    exp_len = 0;
    for (int s = 0; s < 12; s++)
      for (int p = 0; p < cnt[s]; p++)
        for (int k = 0; k < 2*h; k++) begin
          exp_wave[exp_len] = (s % 2 == 0) && (k < h);
          exp_len++;
        end
  endtask

  task automatic wait_busy(output int n, output int dones);
    n = 0; dones = 0;
    while (!busy && n < 400) begin
      @(posedge clk); @(negedge clk);
      n++;
      if (packet_done) dones++;
    end
  endtask

  // Entered at the first busy cycle; chg_at >= 0 swaps inputs to pend_* mid-packet.
  task automatic run_packet(input string name, input int chg_at, input int exp_l, input int exp_r);
    int len, rises, errs, prev;
    len = 0; rises = 0; errs = 0; prev = 0;
    while (busy && len < 256) begin
      wave[len] = ir_led;
      if (ir_led && prev == 0) rises++;
      prev = int'(ir_led);
      if (len == chg_at) begin car = pend_car; command = pend_cmd; end
      len++;
      @(negedge clk);
    end
    for (int i = 0; i < len && i < exp_len; i++)
      if (wave[i] != exp_wave[i]) errs++;
    chk({name, " length"}, len, exp_l);
    chk({name, " rising edges"}, rises, exp_r);
    chk({name, " waveform diffs"}, errs, 0);
    chk({name, " done pulse"}, int'(packet_done), 1);
    chk({name, " led at done"}, int'(ir_led), 0);
    @(negedge clk);
    chk({name, " done one cycle"}, int'(packet_done), 0);
  endtask

  initial begin
    int n, d, e, launches, first_l, second_l, dones_b, prev_b;
    car = mk_car(2, 3, 2, 1, 2, 1);
    command = 4'b0101;
    pend_car = car; pend_cmd = command;
    repeat (3) @(negedge clk);
    chk("reset ir_led", int'(ir_led), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset packet_done", int'(packet_done), 0);

    reset = 1'b0;
    wait_busy(n, d);
    chk("first launch delay", n, 100);
    chk("first led high at t+1", int'(ir_led), 1);
    build_expected(2, 3, 2, 1, 2, 1, 4'b0101);
    run_packet("p1", -1, 68, 11);

    command = 4'b1111;
    build_expected(2, 3, 2, 1, 2, 1, 4'b1111);
    wait_busy(n, d);
    chk("p2 launch spacing", n, 31);
    pend_car = mk_car(0, 3, 2, 1, 2, 1);
    pend_cmd = 4'b0101;
    run_packet("p2", 10, 76, 13);

    build_expected(0, 3, 2, 1, 2, 1, 4'b0101);
    wait_busy(n, d);
    run_packet("p3 hp0", -1, 34, 11);

    car = mk_car(2, 3, 0, 0, 2, 1);
    build_expected(2, 3, 0, 0, 2, 1, 4'b0101);
    wait_busy(n, d);
    run_packet("p4 zero gaps", -1, 36, 9);

    car = mk_car(2, 3, 2, 1, 2, 1);
    wait_busy(n, d);
    repeat (19) @(negedge clk);
    chk("busy before reset", int'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort ir_led", int'(ir_led), 0);
    chk("abort busy", int'(busy), 0);
    chk("abort packet_done", int'(packet_done), 0);
    reset = 1'b0;
    wait_busy(n, d);
    chk("relaunch delay", n, 100);
    chk("no done after abort", d, 0);

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    launches = 0; first_l = 0; second_l = 0; dones_b = 0; prev_b = 0;
    for (e = 1; e <= 200; e++) begin
      @(posedge clk); @(negedge clk);
      if (busy_b && prev_b == 0) begin
        launches++;
        if (launches == 1) first_l = e;
        if (launches == 2) second_l = e;
      end
      prev_b = int'(busy_b);
      if (packet_done_b) dones_b++;
    end
    chk("tick50 launches", launches, 2);
    chk("tick50 first launch", first_l, 50);
    chk("tick50 second launch", second_l, 150);
    chk("tick50 dones", dones_b, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
